// File: rtl/sum_serial_nb.sv
// sum_serial_nb -- digit-serial adder/subtractor with valid/ready handshakes.
//
// A WIDTH-bit add (A+B+cin) or subtract (A+~B+1) is run CHUNK bits per clock,
// LSB chunk first, through one CHUNK-bit adder slice with a registered carry.
// Timeline: accept edge, NCH slice edges, then one commit edge that copies the
// finished result into the output registers and raises o_valid. Outputs only
// change on that commit, so partial sums are never visible on o_Suma.
//
// Optional build macro: SUM_SERIAL_OVF_EN adds o_Ovf (signed overflow).
module sum_serial_nb #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_bit1,
  input  logic [WIDTH-1:0] i_bit2,
  input  logic             i_Carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_Suma,
  output logic             o_Carry
`ifdef SUM_SERIAL_OVF_EN
  ,
  output logic             o_Ovf
`endif
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCH        = (WIDTH / CHUNK_SAFE < 1) ? 1 : WIDTH / CHUNK_SAFE;
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1;

  // Reject geometries the slice datapath cannot cover exactly.
  if (CHUNK < 1 || (WIDTH % CHUNK_SAFE) != 0) begin : g_param_err
    $error("sum_serial_nb: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             fin;     // all slices done; next BUSY edge commits

  logic [CHUNK-1:0] a_chk;
  logic [CHUNK-1:0] b_chk;
  logic [CHUNK:0]   slice;

  // Single CHUNK-bit slice: selected operand chunks plus the running carry.
  always_comb begin
    a_chk = a_r[cnt*CHUNK +: CHUNK];
    b_chk = b_r[cnt*CHUNK +: CHUNK];
    slice = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, cy};
  end

`ifdef SUM_SERIAL_OVF_EN
  logic ovf_r;
  logic ovf_next;
  // Carry into the MSB is recovered from the MSB sum bit; XOR with carry-out.
  always_comb begin
    ovf_next = slice[CHUNK] ^ (a_chk[CHUNK-1] ^ b_chk[CHUNK-1] ^ slice[CHUNK-1]);
  end
`endif

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      cy      <= 1'b0;
      cnt     <= '0;
      fin     <= 1'b0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_Suma  <= '0;
      o_Carry <= 1'b0;
`ifdef SUM_SERIAL_OVF_EN
      ovf_r   <= 1'b0;
      o_Ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            a_r     <= i_bit1;
            b_r     <= i_sub ? ~i_bit2 : i_bit2;
            cy      <= i_sub ? 1'b1 : i_Carry;
            cnt     <= '0;
            fin     <= 1'b0;
            o_ready <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (fin) begin
            // Commit: the only place the visible result changes.
            o_Suma  <= res_r;
            o_Carry <= cy;
`ifdef SUM_SERIAL_OVF_EN
            o_Ovf   <= ovf_r;
`endif
            o_valid <= 1'b1;
            fin     <= 1'b0;
            state   <= DONE;
          end else begin
            res_r[cnt*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
            cy <= slice[CHUNK];
`ifdef SUM_SERIAL_OVF_EN
            ovf_r <= ovf_next;
`endif
            if (cnt == CW'(NCH - 1)) fin <= 1'b1;
            else                     cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // Result held until downstream takes it; new requests wait.
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_serial_nb.sv
// Directed bench for sum_serial_nb: 8/4 table vectors, DONE back-pressure,
// 16/4 wide carry and mid-BUSY reset, 8/8 single-slice case.
module tb_sum_serial_nb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst16;
  int   sel;
  logic req_valid, req_ready, req_cin, req_sub;
  logic [15:0] req_a, req_b;

  int checks = 0;
  int errors = 0;

  // 8/4 instance
  logic rdy8, vld8, c8;
  logic [7:0] sum8;
  // 16/4 instance
  logic rdy16, vld16, c16;
  logic [15:0] sum16;
  // 8/8 instance
  logic rdy88, vld88, c88;
  logic [7:0] sum88;
`ifdef SUM_SERIAL_OVF_EN
  logic ov8, ov16, ov88;
`endif

  sum_serial_nb #(.WIDTH(8), .CHUNK(4)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(req_valid && sel == 0), .o_ready(rdy8),
    .i_bit1(req_a[7:0]), .i_bit2(req_b[7:0]), .i_Carry(req_cin), .i_sub(req_sub),
    .o_valid(vld8), .i_ready(req_ready), .o_Suma(sum8), .o_Carry(c8)
`ifdef SUM_SERIAL_OVF_EN
    , .o_Ovf(ov8)
`endif
  );

  sum_serial_nb #(.WIDTH(16), .CHUNK(4)) dut16 (
    .i_clk(clk), .i_rst_n(rst16), .i_valid(req_valid && sel == 1), .o_ready(rdy16),
    .i_bit1(req_a), .i_bit2(req_b), .i_Carry(req_cin), .i_sub(req_sub),
    .o_valid(vld16), .i_ready(req_ready), .o_Suma(sum16), .o_Carry(c16)
`ifdef SUM_SERIAL_OVF_EN
    , .o_Ovf(ov16)
`endif
  );

  sum_serial_nb #(.WIDTH(8), .CHUNK(8)) dut88 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(req_valid && sel == 2), .o_ready(rdy88),
    .i_bit1(req_a[7:0]), .i_bit2(req_b[7:0]), .i_Carry(req_cin), .i_sub(req_sub),
    .o_valid(vld88), .i_ready(req_ready), .o_Suma(sum88), .o_Carry(c88)
`ifdef SUM_SERIAL_OVF_EN
    , .o_Ovf(ov88)
`endif
  );

  logic cur_ready, cur_valid, cur_c, cur_ov;
  logic [15:0] cur_sum;
  always_comb begin
    cur_ov = 1'b0;
    case (sel)
      1: begin cur_ready = rdy16; cur_valid = vld16; cur_c = c16; cur_sum = sum16; end
      2: begin cur_ready = rdy88; cur_valid = vld88; cur_c = c88; cur_sum = {8'h0, sum88}; end
      default: begin cur_ready = rdy8; cur_valid = vld8; cur_c = c8; cur_sum = {8'h0, sum8}; end
    endcase
`ifdef SUM_SERIAL_OVF_EN
    cur_ov = (sel == 1) ? ov16 : (sel == 2) ? ov88 : ov8;
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full transaction with i_ready held high; lat counts edges after accept.
  task automatic op(input int s, input logic [15:0] a, input logic [15:0] b,
                    input logic cin, input logic sub,
                    output logic [15:0] sum, output logic c, output logic ov,
                    output int lat);
    int n;
    sel = s;
    n = 0;
    #0;
    while (!cur_ready && n < 50) begin tick(); n++; end
    chk("ready_before_req", 32'(cur_ready), 32'd1);
    req_a = a; req_b = b; req_cin = cin; req_sub = sub;
    req_valid = 1'b1; req_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!cur_valid && lat < 50) begin tick(); lat++; end
    sum = cur_sum; c = cur_c; ov = cur_ov;
    tick();  // handshake edge
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] sum;
    logic       c, ov;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [15:0] s;
    logic c, ov;
    int lat;
    int seen;

    vecs[0] = '{8'd20,  8'd30,  1'b0, 1'b0, 8'd50,  1'b0, 1'b0};
    vecs[1] = '{8'd250, 8'd10,  1'b0, 1'b0, 8'd4,   1'b1, 1'b0};
    vecs[2] = '{8'd255, 8'd255, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0};
    vecs[3] = '{8'd100, 8'd150, 1'b1, 1'b1, 8'd206, 1'b0, 1'b1};
    vecs[4] = '{8'd150, 8'd100, 1'b1, 1'b1, 8'd50,  1'b1, 1'b1};
    vecs[5] = '{8'd127, 8'd1,   1'b1, 1'b0, 8'h81,  1'b0, 1'b1};
    vecs[6] = '{8'd128, 8'd128, 1'b0, 1'b0, 8'd0,   1'b1, 1'b1};
    vecs[7] = '{8'd5,   8'd5,   1'b1, 1'b1, 8'd0,   1'b1, 1'b0};
    vecs[8] = '{8'd0,   8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0};
    vecs[9] = '{8'h0F,  8'h01,  1'b0, 1'b0, 8'h10,  1'b0, 1'b0};

    sel = 0; req_valid = 0; req_ready = 0; req_cin = 0; req_sub = 0;
    req_a = '0; req_b = '0;
    rst_n = 0; rst16 = 0;
    #1;
    chk("reset_sum8",   32'(sum8), 32'd0);
    chk("reset_valid8", 32'(vld8), 32'd0);
    chk("reset_carry8", 32'(c8),   32'd0);
    #22;
    @(negedge clk); rst_n = 1; rst16 = 1;
    tick();
    chk("idle_ready8", 32'(rdy8), 32'd1);

    // Table-driven 8/4 vectors; latency NCH+1 = 3 edges after accept.
    for (int i = 0; i < 10; i++) begin
      op(0, {8'h0, vecs[i].a}, {8'h0, vecs[i].b}, vecs[i].cin, vecs[i].sub, s, c, ov, lat);
      chk($sformatf("v%0d_sum", i),   32'(s[7:0]), 32'(vecs[i].sum));
      chk($sformatf("v%0d_carry", i), 32'(c),      32'(vecs[i].c));
      chk($sformatf("v%0d_lat", i),   32'(lat),    32'd3);
`ifdef SUM_SERIAL_OVF_EN
      chk($sformatf("v%0d_ovf", i),   32'(ov),     32'(vecs[i].ov));
`endif
    end

    // Back-pressure in DONE: held result, new request ignored, then accepted.
    sel = 0;
    req_a = 16'd20; req_b = 16'd30; req_cin = 0; req_sub = 0;
    req_ready = 0; req_valid = 1;
    tick();
    req_valid = 0;
    lat = 0;
    while (!vld8 && lat < 50) begin tick(); lat++; end
    chk("hold_lat", 32'(lat), 32'd3);
    req_valid = 1; req_a = 16'd1; req_b = 16'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(vld8), 32'd1);
      chk("hold_sum",   32'(sum8), 32'd50);
      chk("hold_ready", 32'(rdy8), 32'd0);
    end
    req_ready = 1;
    tick();
    chk("release_valid", 32'(vld8), 32'd0);
    chk("release_ready", 32'(rdy8), 32'd1);
    tick();  // pending request accepted here
    req_valid = 0;
    lat = 0;
    while (!vld8 && lat < 50) begin tick(); lat++; end
    chk("after_hold_sum", 32'(sum8), 32'd2);
    chk("after_hold_lat", 32'(lat),  32'd3);
    tick();

    // 16/4: carry through all four slices, latency 5.
    op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, ov, lat);
    chk("w16_sum",   32'(s),   32'h0000);
    chk("w16_carry", 32'(c),   32'd1);
    chk("w16_lat",   32'(lat), 32'd5);
    op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, s, c, ov, lat);
    chk("w16b_sum",  32'(s),   32'h5555);

    // Mid-BUSY reset on the 16-bit instance.
    sel = 1;
    req_a = 16'h00FF; req_b = 16'h0001; req_valid = 1; req_ready = 1;
    tick();
    req_valid = 0;
    tick();
    @(negedge clk); rst16 = 0;
    #1;
    chk("rst_busy_sum",   32'(sum16), 32'd0);
    chk("rst_busy_valid", 32'(vld16), 32'd0);
    chk("rst_busy_carry", 32'(c16),   32'd0);
    tick(); tick();
    @(negedge clk); rst16 = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (vld16) seen++; end
    chk("rst_no_valid", 32'(seen),  32'd0);
    chk("rst_ready",    32'(rdy16), 32'd1);

    // 8/8: single BUSY slice, latency 2.
    op(2, 16'd200, 16'd100, 1'b0, 1'b0, s, c, ov, lat);
    chk("w88_sum",   32'(s[7:0]), 32'd44);
    chk("w88_carry", 32'(c),      32'd1);
    chk("w88_lat",   32'(lat),    32'd2);
    op(2, 16'd10, 16'd20, 1'b1, 1'b1, s, c, ov, lat);
    chk("w88_sub_sum",   32'(s[7:0]), 32'd246);
    chk("w88_sub_carry", 32'(c),      32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
